// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR output stage.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } fir_dec_state_t;

  // Counter width for a modulus n: clog2(n), never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and occupancy count.
// Head reads 0 while empty; a push into an empty FIFO is visible next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]    count, remaining;
  logic             do_push, do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  // Pop ignored when empty; push into a full FIFO only if a pop frees a slot.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign rd_next   = rd_ptr + AW'(do_pop);
  assign remaining = count - CW'(do_pop);

  // Storage array, no reset needed: occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers, count and the registered head word.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_next;
      count  <= remaining + CW'(do_push);
      // Next head is either an entry already stored, the word being pushed
      // into an otherwise empty FIFO, or 0.
      if (remaining != '0)  rdata <= mem[rd_next];
      else if (do_push)     rdata <= wdata;
      else                  rdata <= '0;
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Drops the FIR fill transient, keeps every DECIM-th sample and buffers
// kept samples behind a valid/ready interface.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCOEFS = 300,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             enable,
  input  logic [WIDTH-1:0] yn,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int FW = cnt_w(NCOEFS);
  localparam int PW = cnt_w(DECIM);
  localparam logic [FW-1:0] FILL_LAST  = FW'((NCOEFS >= 2) ? NCOEFS - 2 : 0);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

  fir_dec_state_t  state, next_state;
  logic [FW-1:0]   fill_cnt;
  logic [PW-1:0]   phase;
  logic            push_req;
  logic            fifo_empty, fifo_full;

  assign push_req  = enable && (state == RUN) && (phase == '0);
  assign out_valid = !fifo_empty;

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= next_state;
  end

  // Next state: FILL lasts NCOEFS-1 cycles; enable low always returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = (NCOEFS == 1) ? RUN : FILL;
      FILL:    if (fill_cnt == FILL_LAST) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = IDLE;
    endcase
    if (!enable) next_state = IDLE;
  end

  // Fill and phase counters; both parked at 0 outside an active stream.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      fill_cnt <= '0;
      phase    <= '0;
    end else if (!enable || state == IDLE) begin
      fill_cnt <= '0;
      phase    <= '0;
    end else begin
      if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
      if (state == RUN)  phase    <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    end
  end

  // Sticky overflow: set on a dropped push, cleared when a new stream starts.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)                          overflow <= 1'b0;
    else if (state == IDLE && enable)     overflow <= 1'b0;
    else if (push_req && fifo_full && !out_ready) overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .nreset (nreset),
    .push   (push_req),
    .pop    (out_ready),
    .flush  (!enable),
    .wdata  (yn),
    .rdata  (out_data),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench: main DUT (NCOEFS=4, DECIM=2, DEPTH=4) plus a degenerate
// DUT (NCOEFS=1, DECIM=1) sharing the same input stream.
module tb_fir_decimator;

  logic       clock = 1'b0;
  logic       nreset, enable, out_ready;
  logic [7:0] yn;
  logic [7:0] out_data, d1_data;
  logic       out_valid, overflow, d1_valid, d1_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fir_decimator #(.WIDTH(8), .NCOEFS(4), .DECIM(2), .DEPTH(4)) dut (
    .clock(clock), .nreset(nreset), .enable(enable), .yn(yn),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  fir_decimator #(.WIDTH(8), .NCOEFS(1), .DECIM(1), .DEPTH(4)) dut1 (
    .clock(clock), .nreset(nreset), .enable(enable), .yn(yn),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .overflow(d1_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge, step the yn ramp.
  task automatic tick();
    @(posedge clock);
    #1;
    yn = yn + 8'd1;
  endtask

  task automatic start_stream(input logic rdy);
    enable    = 1'b1;
    yn        = 8'd1;
    out_ready = rdy;
  endtask

  // Stream from IDLE with ready held: main DUT yields 5,7,9,... ; the
  // degenerate DUT yields 2,3,4,... one per cycle.
  task automatic run_ramp();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("ramp_valid", out_valid, (k >= 5 && k % 2 == 1));
      chk("ramp_data",  out_data,  (k >= 5 && k % 2 == 1) ? k : 0);
      chk("ramp_ovf",   overflow,  0);
      chk("d1_valid",   d1_valid,  (k >= 2));
      chk("d1_data",    d1_data,   (k >= 2) ? k : 0);
      chk("d1_ovf",     d1_ovf,    0);
    end
  endtask

  initial begin
    int exp_q[6];
    nreset = 1'b0; enable = 1'b0; out_ready = 1'b0; yn = 8'd0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_ovf",   overflow,  0);
    @(posedge clock); #1;
    nreset = 1'b1;

    // Fill / decimate with ready held.
    start_stream(1'b1);
    run_ramp();

    // Back-pressure: fill with 5,7,9,11, drop 13, then drain.
    enable = 1'b0;
    tick();
    start_stream(1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("bp_valid", out_valid, (k >= 5));
      chk("bp_data",  out_data,  (k >= 5) ? 5 : 0);
      chk("bp_ovf",   overflow,  0);
    end
    tick();
    chk("bp_drop_ovf",  overflow, 1);
    chk("bp_drop_data", out_data, 5);
    out_ready = 1'b1;
    exp_q = '{7, 9, 11, 15, 17, 19};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_drain", out_data, exp_q[i]);
    end
    tick();
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_ovf_sticky",  overflow,  1);

    // Full FIFO with simultaneous push and pop.
    enable = 1'b0;
    tick();
    chk("idle_ovf_held", overflow, 1);
    start_stream(1'b0);
    tick();
    chk("reen_ovf_clr", overflow, 0);
    for (int k = 2; k <= 11; k++) tick();
    chk("full_head", out_data, 5);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_head",  out_data, 7);
    chk("pp_ovf",   overflow, 0);
    tick();
    tick();
    chk("pp_still_full_ovf", overflow, 1);
    chk("pp_still_head",     out_data, 7);
    out_ready = 1'b1;
    exp_q = '{9, 11, 13, 17, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pp_drain", out_data, exp_q[i]);
    end

    // Enable drop with 3 entries queued.
    out_ready = 1'b0;
    tick();
    tick();
    chk("q3_valid", out_valid, 1);
    chk("q3_head",  out_data,  17);
    enable = 1'b0;
    tick();
    chk("drop_valid", out_valid, 0);
    chk("drop_data",  out_data,  0);
    chk("drop_ovf",   overflow,  1);
    tick();
    chk("drop_idle_valid", out_valid, 0);
    start_stream(1'b1);
    tick();
    chk("restart_ovf", overflow, 0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("restart_fill_valid", out_valid, 0);
    end
    tick();
    chk("restart_valid", out_valid, 1);
    chk("restart_data",  out_data,  5);
    tick();
    tick();
    chk("restart_data2", out_data, 7);
    chk("pre_rst_d1",    d1_valid, 1);

    // Async reset between edges, mid-RUN.
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_valid",    out_valid, 0);
    chk("arst_data",     out_data,  0);
    chk("arst_ovf",      overflow,  0);
    chk("arst_d1_valid", d1_valid,  0);
    chk("arst_d1_data",  d1_data,   0);
    #1;
    nreset = 1'b1;
    start_stream(1'b1);
    run_ramp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
